// File: rtl/mul_div_unit.sv
// Warp-wide integer multiply/divide execution unit: a fixed-depth multiplier pipeline
// alongside an iterative restoring divider, with results returned out of order.
module mul_div_unit #(
    parameter int NumTags     = 8,
    parameter int RegWidth    = 32,
    parameter int WarpWidth   = 4,
    parameter int NumWarps    = 8,
    parameter int RegIdxWidth = 8,
    parameter int MulStages   = 3,
    localparam int TagWidth   = $clog2(NumTags),
    localparam int WidWidth   = NumWarps > 1 ? $clog2(NumWarps) : 1,
    localparam int IidWidth   = TagWidth + WidWidth
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   opc_to_eu_valid_i,
    output logic                                   eu_to_opc_ready_o,
    input  logic [IidWidth-1:0]                    opc_to_eu_tag_i,
    input  logic [WarpWidth-1:0]                   opc_to_eu_act_mask_i,
    input  logic [RegIdxWidth-1:0]                 opc_to_eu_dst_i,
    input  logic [2:0]                             opc_to_eu_op_i,
    input  logic [1:0][RegWidth*WarpWidth-1:0]     opc_to_eu_operands_i,
    input  logic                                   rc_to_eu_ready_i,
    output logic                                   eu_to_rc_valid_o,
    output logic [IidWidth-1:0]                    eu_to_rc_tag_o,
    output logic [WarpWidth-1:0]                   eu_to_rc_act_mask_o,
    output logic [RegIdxWidth-1:0]                 eu_to_rc_dst_o,
    output logic [RegWidth*WarpWidth-1:0]          eu_to_rc_data_o
);

    localparam int CntWidth = RegWidth > 1 ? $clog2(RegWidth) : 1;
    localparam int Last     = MulStages - 1;

    localparam logic [2:0] OpMul   = 3'd0;
    localparam logic [2:0] OpMulh  = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpRem   = 3'd5;
    localparam logic [2:0] OpRemu  = 3'd6;
    localparam logic [2:0] OpOnes  = 3'd7;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    function automatic logic [2*RegWidth-1:0] extend(input logic [RegWidth-1:0] v, input logic sgn);
        return sgn ? {{RegWidth{v[RegWidth-1]}}, v} : {{RegWidth{1'b0}}, v};
    endfunction

    logic [WarpWidth-1:0][RegWidth-1:0] op_a;
    logic [WarpWidth-1:0][RegWidth-1:0] op_b;
    logic                               is_div_op;
    logic                               mul_accept;
    logic                               div_accept;
    logic                               mul_fire;
    logic                               mul_advance;

    logic [MulStages-1:0]               mul_valid;
    logic [IidWidth-1:0]                mul_tag  [MulStages];
    logic [WarpWidth-1:0]               mul_mask [MulStages];
    logic [RegIdxWidth-1:0]             mul_dst  [MulStages];
    logic [2:0]                         mul_op   [MulStages];
    logic [WarpWidth-1:0][2*RegWidth-1:0] mul_prod [MulStages];
    logic [WarpWidth-1:0][2*RegWidth-1:0] prod_in;

    div_state_e                         div_state;
    logic [CntWidth-1:0]                div_cnt;
    logic [WarpWidth-1:0][RegWidth-1:0] div_quo;
    logic [WarpWidth-1:0][RegWidth-1:0] div_rem;
    logic [WarpWidth-1:0][RegWidth-1:0] div_dsr;
    logic [WarpWidth-1:0][RegWidth-1:0] div_result;
    logic [WarpWidth-1:0]               div_qneg;
    logic [WarpWidth-1:0]               div_rneg;
    logic                               div_is_rem;
    logic [IidWidth-1:0]                div_tag;
    logic [WarpWidth-1:0]               div_mask;
    logic [RegIdxWidth-1:0]             div_dst;

    logic                               div_signed;
    logic [WarpWidth-1:0][RegWidth-1:0] lat_quo;
    logic [WarpWidth-1:0][RegWidth-1:0] lat_dsr;
    logic [WarpWidth-1:0]               lat_qneg;
    logic [WarpWidth-1:0]               lat_rneg;
    logic [WarpWidth-1:0]               lat_bneg;
    logic [WarpWidth-1:0][RegWidth-1:0] quo_nxt;
    logic [WarpWidth-1:0][RegWidth-1:0] rem_nxt;
    logic [WarpWidth-1:0][RegWidth-1:0] res_nxt;
    logic [RegWidth:0]                  shifted;
    logic                               fits;

    assign op_a = opc_to_eu_operands_i[1];
    assign op_b = opc_to_eu_operands_i[0];

    // The mul pipeline only moves as a whole; a stalled last stage freezes every stage.
    assign is_div_op   = (opc_to_eu_op_i >= OpDiv) && (opc_to_eu_op_i <= OpRemu);
    assign mul_fire    = mul_valid[Last] && (div_state != DIV_DONE) && rc_to_eu_ready_i;
    assign mul_advance = !mul_valid[Last] || mul_fire;
    assign eu_to_opc_ready_o = is_div_op ? (div_state == DIV_IDLE) : mul_advance;
    assign mul_accept  = opc_to_eu_valid_i && eu_to_opc_ready_o && !is_div_op;
    assign div_accept  = opc_to_eu_valid_i && eu_to_opc_ready_o && is_div_op;

    always_comb begin
        prod_in = '0;
        for (int i = 0; i < WarpWidth; i++) begin
            if (opc_to_eu_op_i == OpOnes) begin
                prod_in[i] = '1;
            end else begin
                prod_in[i] = extend(op_a[i], opc_to_eu_op_i == OpMulh)
                           * extend(op_b[i], opc_to_eu_op_i == OpMulh);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mul_valid <= '0;
        end else if (mul_advance) begin
            mul_valid[0] <= mul_accept;
            for (int s = 1; s < MulStages; s++) begin
                mul_valid[s] <= mul_valid[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mul_advance) begin
            mul_tag[0]  <= opc_to_eu_tag_i;
            mul_mask[0] <= opc_to_eu_act_mask_i;
            mul_dst[0]  <= opc_to_eu_dst_i;
            mul_op[0]   <= opc_to_eu_op_i;
            mul_prod[0] <= prod_in;
            for (int s = 1; s < MulStages; s++) begin
                mul_tag[s]  <= mul_tag[s-1];
                mul_mask[s] <= mul_mask[s-1];
                mul_dst[s]  <= mul_dst[s-1];
                mul_op[s]   <= mul_op[s-1];
                mul_prod[s] <= mul_prod[s-1];
            end
        end
    end

    // Divider works on magnitudes; signs are re-applied once, on the final iteration.
    always_comb begin
        div_signed = (opc_to_eu_op_i == OpDiv) || (opc_to_eu_op_i == OpRem);
        lat_quo  = '0;
        lat_dsr  = '0;
        lat_qneg = '0;
        lat_rneg = '0;
        lat_bneg = '0;
        for (int i = 0; i < WarpWidth; i++) begin
            lat_rneg[i] = div_signed && op_a[i][RegWidth-1];
            lat_bneg[i] = div_signed && op_b[i][RegWidth-1];
            lat_quo[i]  = lat_rneg[i] ? -op_a[i] : op_a[i];
            lat_dsr[i]  = lat_bneg[i] ? -op_b[i] : op_b[i];
            lat_qneg[i] = (lat_rneg[i] ^ lat_bneg[i]) && (op_b[i] != '0);
        end
    end

    always_comb begin
        quo_nxt = '0;
        rem_nxt = '0;
        res_nxt = '0;
        shifted = '0;
        fits    = 1'b0;
        for (int i = 0; i < WarpWidth; i++) begin
            shifted    = {div_rem[i], div_quo[i][RegWidth-1]};
            fits       = shifted >= {1'b0, div_dsr[i]};
            rem_nxt[i] = fits ? shifted[RegWidth-1:0] - div_dsr[i] : shifted[RegWidth-1:0];
            quo_nxt[i] = {div_quo[i][RegWidth-2:0], fits};
            if (div_is_rem) begin
                res_nxt[i] = div_rneg[i] ? -rem_nxt[i] : rem_nxt[i];
            end else begin
                res_nxt[i] = div_qneg[i] ? -quo_nxt[i] : quo_nxt[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_state  <= DIV_IDLE;
            div_cnt    <= '0;
            div_quo    <= '0;
            div_rem    <= '0;
            div_dsr    <= '0;
            div_result <= '0;
            div_qneg   <= '0;
            div_rneg   <= '0;
            div_is_rem <= 1'b0;
            div_tag    <= '0;
            div_mask   <= '0;
            div_dst    <= '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (div_accept) begin
                        div_quo    <= lat_quo;
                        div_dsr    <= lat_dsr;
                        div_rem    <= '0;
                        div_qneg   <= lat_qneg;
                        div_rneg   <= lat_rneg;
                        div_is_rem <= (opc_to_eu_op_i == OpRem) || (opc_to_eu_op_i == OpRemu);
                        div_tag    <= opc_to_eu_tag_i;
                        div_mask   <= opc_to_eu_act_mask_i;
                        div_dst    <= opc_to_eu_dst_i;
                        div_cnt    <= CntWidth'(RegWidth - 1);
                        div_state  <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    div_quo <= quo_nxt;
                    div_rem <= rem_nxt;
                    if (div_cnt == '0) begin
                        div_result <= res_nxt;
                        div_state  <= DIV_DONE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (rc_to_eu_ready_i) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    // A finished division always wins the result port over the multiplier.
    always_comb begin
        eu_to_rc_valid_o    = 1'b0;
        eu_to_rc_tag_o      = '0;
        eu_to_rc_act_mask_o = '0;
        eu_to_rc_dst_o      = '0;
        eu_to_rc_data_o     = '0;
        if (div_state == DIV_DONE) begin
            eu_to_rc_valid_o    = 1'b1;
            eu_to_rc_tag_o      = div_tag;
            eu_to_rc_act_mask_o = div_mask;
            eu_to_rc_dst_o      = div_dst;
            eu_to_rc_data_o     = div_result;
        end else if (mul_valid[Last]) begin
            eu_to_rc_valid_o    = 1'b1;
            eu_to_rc_tag_o      = mul_tag[Last];
            eu_to_rc_act_mask_o = mul_mask[Last];
            eu_to_rc_dst_o      = mul_dst[Last];
            for (int i = 0; i < WarpWidth; i++) begin
                eu_to_rc_data_o[i*RegWidth +: RegWidth] = (mul_op[Last] == OpMul)
                    ? mul_prod[Last][i][RegWidth-1:0]
                    : mul_prod[Last][i][2*RegWidth-1:RegWidth];
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic corner cases, latency,
// output priority, back-pressure and mid-operation reset.
module tb_mul_div_unit;

    localparam int IidWidth  = 6;
    localparam int DataWidth = 128;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  opc_valid = 1'b0;
    logic                  opc_ready;
    logic [IidWidth-1:0]   opc_tag = '0;
    logic [3:0]            opc_mask = '0;
    logic [7:0]            opc_dst = '0;
    logic [2:0]            opc_op = '0;
    logic [1:0][DataWidth-1:0] opc_operands = '0;
    logic                  rc_ready = 1'b0;
    logic                  rc_valid;
    logic [IidWidth-1:0]   rc_tag;
    logic [3:0]            rc_mask;
    logic [7:0]            rc_dst;
    logic [DataWidth-1:0]  rc_data;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int t_div, t_mul, t_rel;
    logic [5:0] next_tag = 6'd1;

    int                   mon_cyc  [$];
    logic [IidWidth-1:0]  mon_tag  [$];
    logic [7:0]           mon_dst  [$];
    logic [3:0]           mon_mask [$];
    logic [DataWidth-1:0] mon_data [$];

    mul_div_unit #(
        .NumTags(8), .RegWidth(32), .WarpWidth(4), .NumWarps(8), .RegIdxWidth(8), .MulStages(3)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .opc_to_eu_valid_i(opc_valid),
        .eu_to_opc_ready_o(opc_ready),
        .opc_to_eu_tag_i(opc_tag),
        .opc_to_eu_act_mask_i(opc_mask),
        .opc_to_eu_dst_i(opc_dst),
        .opc_to_eu_op_i(opc_op),
        .opc_to_eu_operands_i(opc_operands),
        .rc_to_eu_ready_i(rc_ready),
        .eu_to_rc_valid_o(rc_valid),
        .eu_to_rc_tag_o(rc_tag),
        .eu_to_rc_act_mask_o(rc_mask),
        .eu_to_rc_dst_o(rc_dst),
        .eu_to_rc_data_o(rc_data)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every completed result transfer mid-cycle, away from input changes.
    always @(negedge clk_i) begin
        if (rc_valid === 1'b1 && rc_ready === 1'b1) begin
            mon_cyc.push_back(cyc);
            mon_tag.push_back(rc_tag);
            mon_dst.push_back(rc_dst);
            mon_mask.push_back(rc_mask);
            mon_data.push_back(rc_data);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DataWidth-1:0] lanes(input logic [31:0] l3, input logic [31:0] l2,
                                                   input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string name, input logic [DataWidth-1:0] actual,
                               input logic [DataWidth-1:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clearMon();
        mon_cyc.delete();
        mon_tag.delete();
        mon_dst.delete();
        mon_mask.delete();
        mon_data.delete();
    endtask

    task automatic waitQueue(input int n, input int budget);
        for (int i = 0; i < budget && mon_tag.size() < n; i++) stepCycle();
    endtask

    // Present one instruction and hold it until accepted; t is the accepting cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [DataWidth-1:0] a,
                                 input logic [DataWidth-1:0] b, input logic [5:0] tag,
                                 input logic [3:0] mask, output int t);
        opc_op          = op;
        opc_operands[1] = a;
        opc_operands[0] = b;
        opc_tag         = tag;
        opc_mask        = mask;
        opc_dst         = {2'b00, tag};
        opc_valid       = 1'b1;
        #1;
        for (int i = 0; i < 100 && opc_ready !== 1'b1; i++) stepCycle();
        t = cyc;
        if (opc_ready !== 1'b1) begin
            checkOutput("accept_timeout", DataWidth'(opc_ready), DataWidth'(1));
            opc_valid = 1'b0;
        end else begin
            stepCycle();
            opc_valid = 1'b0;
        end
    endtask

    task automatic runDirected(input string name, input logic [2:0] op,
                               input logic [DataWidth-1:0] a, input logic [DataWidth-1:0] b,
                               input logic [3:0] mask, input logic [DataWidth-1:0] expected,
                               input int lat);
        int t;
        logic [5:0] tag;
        tag = next_tag;
        next_tag = next_tag + 6'd1;
        clearMon();
        applyStimulus(op, a, b, tag, mask, t);
        if (op >= 3'd3 && op <= 3'd6)
            checkOutput({name, "_busy_ready"}, DataWidth'(opc_ready), DataWidth'(0));
        waitQueue(1, 60);
        if (mon_tag.size() == 0) begin
            checkOutput({name, "_timeout"}, DataWidth'(mon_tag.size()), DataWidth'(1));
        end else begin
            checkOutput({name, "_latency"}, DataWidth'(mon_cyc[0] - t), DataWidth'(lat));
            checkOutput({name, "_data"}, mon_data[0], expected);
            checkOutput({name, "_meta"}, {mon_tag[0], mon_dst[0], mon_mask[0]},
                        {tag, 2'b00, tag, mask});
        end
    endtask

    initial begin
        // Reset state
        repeat (3) stepCycle();
        rst_ni = 1'b1;
        #1;
        checkOutput("rst_valid", DataWidth'(rc_valid), DataWidth'(0));
        checkOutput("rst_meta", {rc_tag, rc_dst, rc_mask}, '0);
        checkOutput("rst_data", rc_data, '0);
        checkOutput("rst_ready_mul", DataWidth'(opc_ready), DataWidth'(1));
        opc_op = 3'd3;
        #1;
        checkOutput("rst_ready_div", DataWidth'(opc_ready), DataWidth'(1));
        stepCycle();
        rc_ready = 1'b1;

        // Arithmetic corner cases
        runDirected("mul", 3'd0, lanes(1, 32'hFFFFFFFF, 32'hFFFFFFFD, 7), lanes(0, 2, 5, 6), 4'hF,
                    lanes(0, 32'hFFFFFFFE, 32'hFFFFFFF1, 42), 3);
        runDirected("mulh", 3'd1, lanes(32'h7FFFFFFF, 32'hFFFFFFFF, 2, 32'h80000000),
                    lanes(32'h7FFFFFFF, 5, 3, 32'h80000000), 4'hF,
                    lanes(32'h3FFFFFFF, 32'hFFFFFFFF, 0, 32'h40000000), 3);
        runDirected("mulhu", 3'd2, lanes(3, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF),
                    lanes(4, 5, 2, 32'hFFFFFFFF), 4'hF, lanes(0, 4, 1, 32'hFFFFFFFE), 3);
        runDirected("ones", 3'd7, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 4'b0101, '1, 3);
        runDirected("div", 3'd3, lanes(32'h80000000, 5, 7, 32'hFFFFFFF9),
                    lanes(32'hFFFFFFFF, 0, 32'hFFFFFFFE, 2), 4'b1010,
                    lanes(32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD), 33);
        runDirected("rem", 3'd5, lanes(32'h80000000, 5, 7, 32'hFFFFFFF9),
                    lanes(32'hFFFFFFFF, 0, 32'hFFFFFFFE, 2), 4'b0011,
                    lanes(0, 5, 1, 32'hFFFFFFFF), 33);
        runDirected("divu", 3'd4, lanes(32'h80000000, 32'hFFFFFFFF, 100, 5),
                    lanes(32'hFFFFFFFF, 2, 7, 0), 4'hF, lanes(0, 32'h7FFFFFFF, 14, 32'hFFFFFFFF), 33);
        runDirected("remu", 3'd6, lanes(32'h80000000, 32'hFFFFFFFF, 100, 5),
                    lanes(32'hFFFFFFFF, 2, 7, 0), 4'hF, lanes(32'h80000000, 1, 2, 5), 33);

        // Multiplies overtake an in-flight divide
        clearMon();
        applyStimulus(3'd3, lanes(100, 32'hFFFFFF9C, 9, 0), lanes(7, 7, 3, 5), 6'h20, 4'hF, t_div);
        for (int k = 0; k < 3; k++)
            applyStimulus(3'd0, lanes(1, 2, 3, 4), lanes(5 + k, 5 + k, 5 + k, 5 + k),
                          6'h21 + 6'(k), 4'hF, t_mul);
        waitQueue(4, 80);
        checkOutput("order_count", DataWidth'(mon_tag.size()), DataWidth'(4));
        if (mon_tag.size() >= 4) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("order_mul%0d_cycle", k), DataWidth'(mon_cyc[k] - t_div),
                            DataWidth'(4 + k));
                checkOutput($sformatf("order_mul%0d_tag", k), DataWidth'(mon_tag[k]),
                            DataWidth'(6'h21 + 6'(k)));
                checkOutput($sformatf("order_mul%0d_data", k), mon_data[k],
                            lanes(5 + k, 2 * (5 + k), 3 * (5 + k), 4 * (5 + k)));
            end
            checkOutput("order_div_cycle", DataWidth'(mon_cyc[3] - t_div), DataWidth'(33));
            checkOutput("order_div_tag", DataWidth'(mon_tag[3]), DataWidth'(6'h20));
            checkOutput("order_div_data", mon_data[3], lanes(14, 32'hFFFFFFF2, 3, 0));
        end

        // Divider completion collides with a multiply reaching the last stage
        clearMon();
        applyStimulus(3'd3, lanes(100, 32'hFFFFFF9C, 9, 0), lanes(7, 7, 3, 5), 6'h24, 4'hF, t_div);
        for (int i = 0; i < 40 && cyc < t_div + 30; i++) stepCycle();
        applyStimulus(3'd0, lanes(1, 2, 3, 4), lanes(9, 9, 9, 9), 6'h25, 4'hF, t_mul);
        checkOutput("coll_accept_cycle", DataWidth'(t_mul - t_div), DataWidth'(30));
        waitQueue(2, 60);
        checkOutput("coll_count", DataWidth'(mon_tag.size()), DataWidth'(2));
        if (mon_tag.size() >= 2) begin
            checkOutput("coll_div_tag", DataWidth'(mon_tag[0]), DataWidth'(6'h24));
            checkOutput("coll_div_cycle", DataWidth'(mon_cyc[0] - t_div), DataWidth'(33));
            checkOutput("coll_div_data", mon_data[0], lanes(14, 32'hFFFFFFF2, 3, 0));
            checkOutput("coll_mul_tag", DataWidth'(mon_tag[1]), DataWidth'(6'h25));
            checkOutput("coll_mul_cycle", DataWidth'(mon_cyc[1] - t_div), DataWidth'(34));
            checkOutput("coll_mul_data", mon_data[1], lanes(9, 18, 27, 36));
        end

        // Back-pressure with the multiplier pipeline full
        rc_ready = 1'b0;
        clearMon();
        for (int k = 0; k < 3; k++)
            applyStimulus(3'd0, lanes(1, 2, 3, 4), lanes(2 + k, 2 + k, 2 + k, 2 + k),
                          6'h30 + 6'(k), 4'hF, t_mul);
        checkOutput("stall_mul_ready", DataWidth'(opc_ready), DataWidth'(0));
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("stall_head%0d", i), DataWidth'({rc_valid, rc_tag}),
                        DataWidth'({1'b1, 6'h30}));
            checkOutput($sformatf("stall_data%0d", i), rc_data, lanes(2, 4, 6, 8));
            stepCycle();
        end
        checkOutput("stall_no_transfer", DataWidth'(mon_tag.size()), DataWidth'(0));
        rc_ready = 1'b1;
        t_rel = cyc;
        waitQueue(3, 20);
        repeat (3) stepCycle();
        checkOutput("release_count", DataWidth'(mon_tag.size()), DataWidth'(3));
        if (mon_tag.size() >= 3) begin
            checkOutput("release_first_cycle", DataWidth'(mon_cyc[0] - t_rel), DataWidth'(0));
            for (int k = 0; k < 3; k++) begin
                if (k > 0)
                    checkOutput($sformatf("release%0d_cycle", k),
                                DataWidth'(mon_cyc[k] - mon_cyc[0]), DataWidth'(k));
                checkOutput($sformatf("release%0d_tag", k), DataWidth'(mon_tag[k]),
                            DataWidth'(6'h30 + 6'(k)));
                checkOutput($sformatf("release%0d_data", k), mon_data[k],
                            lanes(2 + k, 2 * (2 + k), 3 * (2 + k), 4 * (2 + k)));
            end
        end

        // Reset while the divider is busy and two multiplies are in flight
        clearMon();
        applyStimulus(3'd3, lanes(100, 32'hFFFFFF9C, 9, 0), lanes(7, 7, 3, 5), 6'h38, 4'hF, t_div);
        applyStimulus(3'd0, lanes(1, 2, 3, 4), lanes(3, 3, 3, 3), 6'h39, 4'hF, t_mul);
        applyStimulus(3'd0, lanes(1, 2, 3, 4), lanes(4, 4, 4, 4), 6'h3A, 4'hF, t_mul);
        rst_ni = 1'b0;
        stepCycle();
        rst_ni = 1'b1;
        opc_op = 3'd3;
        #1;
        checkOutput("post_rst_ready_div", DataWidth'(opc_ready), DataWidth'(1));
        opc_op = 3'd0;
        #1;
        checkOutput("post_rst_ready_mul", DataWidth'(opc_ready), DataWidth'(1));
        checkOutput("post_rst_valid", DataWidth'(rc_valid), DataWidth'(0));
        repeat (50) stepCycle();
        checkOutput("post_rst_no_results", DataWidth'(mon_tag.size()), DataWidth'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter NumTags, default 8: inflight instructions per warp.
REQ-002 SHALL have parameter RegWidth, default 32: lane data width.
REQ-003 SHALL have parameter WarpWidth, default 4: lanes per warp.
REQ-004 SHALL have parameter NumWarps, default 8: warps per compute unit.
REQ-005 SHALL have parameter RegIdxWidth, default 8: destination register index width.
REQ-006 SHALL have parameter MulStages, default 3 (legal >=1): multiplier pipeline depth.
REQ-007 SHALL derive TagWidth = $clog2(NumTags), WidWidth = NumWarps>1 ? $clog2(NumWarps) : 1, IidWidth = TagWidth+WidWidth; these SHALL NOT be overridden.
REQ-008 SHALL have port clk_i, input, 1: sole clock; all state on rising edge.
REQ-009 SHALL have port rst_ni, input, 1: synchronous active-low reset.
REQ-010 SHALL have ports opc_to_eu_valid_i in 1, eu_to_opc_ready_o out 1: input handshake.
REQ-011 SHALL have inputs opc_to_eu_tag_i IidWidth, opc_to_eu_act_mask_i WarpWidth, opc_to_eu_dst_i RegIdxWidth, opc_to_eu_op_i 3: instruction id, active lanes, destination, opcode.
REQ-012 SHALL have input opc_to_eu_operands_i, 2 x RegWidth*WarpWidth: operand[1] = rs1 (dividend / multiplicand), operand[0] = rs2; lane i at bits [i*RegWidth +: RegWidth].
REQ-013 SHALL have ports rc_to_eu_ready_i in 1, eu_to_rc_valid_o out 1, eu_to_rc_tag_o out IidWidth, eu_to_rc_act_mask_o out WarpWidth, eu_to_rc_dst_o out RegIdxWidth, eu_to_rc_data_o out RegWidth*WarpWidth.

Function
REQ-014 Opcodes SHALL be 0 MUL (low half), 1 MULH (signed x signed, high half), 2 MULHU (unsigned, high half), 3 DIV, 4 DIVU, 5 REM, 6 REMU; 7 SHALL return all-ones per lane, routed through the multiplier path.
REQ-015 Handshake SHALL be valid/ready: transfer iff valid && ready; a valid held without ready SHALL keep all payloads stable.
REQ-016 Multiplier path SHALL be a MulStages-deep pipeline carrying valid, tag, act_mask, dst, op and per-lane partial data; full product width 2*RegWidth.
REQ-017 Multiplier pipeline SHALL advance as a whole when its last stage is empty or is consumed this cycle, else hold entirely; bubbles SHALL NOT be compressed.
REQ-018 Unstalled, a multiply accepted in cycle T SHALL present eu_to_rc_valid_o in cycle T+MulStages; back-to-back multiplies SHALL sustain one per cycle.
REQ-019 Divider SHALL be an FSM IDLE -> BUSY -> DONE -> IDLE, all lanes in parallel, restoring radix-2, one quotient bit per cycle.
REQ-020 IDLE: accept a div/rem op; latch magnitudes, result signs, metadata; counter = RegWidth-1; go BUSY.
REQ-021 BUSY: one iteration per cycle; after the iteration with counter 0 go DONE; a div accepted in cycle T SHALL present valid in T+RegWidth+1 if unblocked.
REQ-022 DONE: drive sign-corrected result; return to IDLE on output transfer; new div SHALL NOT be accepted in the same cycle.
REQ-023 eu_to_opc_ready_o SHALL be 1 for mul ops iff the pipeline advances this cycle, and for div/rem ops iff the divider is IDLE; it SHALL NOT depend on opc_to_eu_valid_i.
REQ-024 Divide by zero: quotient = all ones, remainder = dividend, per lane.
REQ-025 Signed overflow (dividend = 2^(RegWidth-1) negative, divisor = -1): quotient = dividend, remainder = 0.
REQ-026 Signed remainder SHALL take the dividend's sign; signed quotient negative iff operand signs differ and divisor nonzero.
REQ-027 Output arbitration: divider DONE SHALL have priority over multiplier last stage; the losing multiplier pipeline SHALL hold per REQ-017.
REQ-028 Results SHALL be returned out of order; act_mask SHALL be carried unchanged, and inactive lanes SHALL still compute (no gating).
REQ-029 Outputs SHALL be driven from registered state through the arbiter mux only; no combinational path from opc_to_eu_* to eu_to_rc_*.

Reset
REQ-030 While rst_ni = 0 at a rising edge: all pipeline valids cleared, divider IDLE, counter 0; in-flight ops SHALL be dropped without output.
REQ-031 After reset, eu_to_rc_valid_o = 0 and eu_to_rc_tag_o, dst_o, act_mask_o, data_o = 0; eu_to_opc_ready_o = 1.

Verification (RegWidth=32, WarpWidth=4, MulStages=3)
REQ-032 MUL lanes 7x6, -3x5, 0xFFFFFFFF x 2, 1x0, rc ready -> valid at T+3, data 42, 0xFFFFFFF1, 0xFFFFFFFE, 0.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 DIV -7/2 -> -3, REM -7/2 -> -1, DIVU 5/0 -> 0xFFFFFFFF, REM 0x80000000/-1 -> 0; valid at T+33, ready_o low for div ops during BUSY.
REQ-035 DIV accepted, then 3 MULs, rc_to_eu_ready_i=1 -> MUL results at T+4..T+6 before the DIV result; DONE coinciding with a MUL result -> DIV first, MUL one cycle later, data and tags intact.
REQ-036 rc_to_eu_ready_i=0 for 10 cycles with pipeline full -> outputs stable, ready_o low for mul ops; release -> 3 results in 3 consecutive cycles, none lost or duplicated.
REQ-037 rst_ni low 1 cycle mid-BUSY with 2 MULs in flight -> no result ever emitted for them; ready_o = 1 the cycle after reset.
